// File: rtl/button_pkg.sv
// Shared types and defaults for the button event generator.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } btn_state_t;

  localparam int LONG_MS_DEF   = 1000;
  localparam int REPEAT_MS_DEF = 200;

endpackage

// File: rtl/edge_detect.sv
// Registers the debounced level and flags its rising and falling edges.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic btn_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_d <= 1'b0;
    end else begin
      btn_d <= level;
    end
  end

  assign rise = level & ~btn_d;
  assign fall = ~level & btn_d;

endmodule

// File: rtl/button_event_gen.sv
// Turns a debounced button level plus a 1 ms strobe into press, short-release,
// long-press and auto-repeat one-clock events.
module button_event_gen
  import button_pkg::*;
#(
  parameter int LONG_MS   = LONG_MS_DEF,
  parameter int REPEAT_MS = REPEAT_MS_DEF,
  parameter int CNT_W     = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_level,
  output logic       press_pulse,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output btn_state_t state_dbg
);

  localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_MS - 1);

  btn_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rise, fall;
  logic             press_nxt, short_nxt, long_nxt, repeat_nxt, held_nxt;

  edge_detect u_edge (
    .clk   (clk),
    .rst   (rst),
    .level (btn_level),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      press_pulse  <= 1'b0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      held         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      press_pulse  <= press_nxt;
      short_pulse  <= short_nxt;
      long_pulse   <= long_nxt;
      repeat_pulse <= repeat_nxt;
      held         <= held_nxt;
    end
  end

  // A release always beats a coincident terminal tick.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    press_nxt  = 1'b0;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (rise) begin
          state_nxt = PRESSED;
          press_nxt = 1'b1;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
          cnt_nxt   = '0;
        end else if (tick && cnt == LONG_TERM) begin
          state_nxt = LONG;
          long_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else if (tick) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      LONG: begin
        if (fall) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (tick && cnt == REPEAT_TERM) begin
          repeat_nxt = 1'b1;
          cnt_nxt    = '0;
        end else if (tick) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    held_nxt = (state_nxt == PRESSED) || (state_nxt == LONG);
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_button_event_gen.sv
// Randomized and directed checks of button_event_gen against a tick-count model.
module tb_button_event_gen;
  import button_pkg::*;

  localparam int LONG_MS   = 5;
  localparam int REPEAT_MS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       btn_level = 1'b0;
  logic       press_pulse, short_pulse, long_pulse, repeat_pulse, held;
  btn_state_t state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int phase   = 0;

  // reference model: button history expressed as ticks counted since the press
  logic m_prev = 1'b0;
  logic m_held = 1'b0;
  int   m_n    = 0;

  int cnt_press, cnt_short, cnt_long, cnt_rep;

  always #5 clk = ~clk;

  button_event_gen #(.LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS), .CNT_W(11)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held),
    .state_dbg    (state_dbg)
  );

  function automatic logic ptick();
    return (phase == 3);
  endfunction

  task automatic clear_counts();
    cnt_press = 0; cnt_short = 0; cnt_long = 0; cnt_rep = 0;
  endtask

  // one clock: drive inputs, step model at the edge, check outputs #1 later
  task automatic cycle(input logic lvl, input logic tk);
    logic [4:0] exp_v, got_v;
    btn_state_t exp_s;
    logic e_press, e_short, e_long, e_rep;
    btn_level = lvl;
    tick      = tk;
    @(posedge clk);
    e_press = 0; e_short = 0; e_long = 0; e_rep = 0;
    if (!rst) begin
      m_prev = 0; m_held = 0; m_n = 0;
    end else begin
      if (lvl && !m_prev) begin
        e_press = 1; m_held = 1; m_n = 0;
      end else if (m_held && !lvl) begin
        e_short = (m_n < LONG_MS);
        m_held  = 0; m_n = 0;
      end else if (m_held && tk) begin
        m_n++;
        if (m_n == LONG_MS) e_long = 1;
        else if (m_n > LONG_MS && (m_n - LONG_MS) % REPEAT_MS == 0) e_rep = 1;
      end
      m_prev = lvl;
    end
    exp_s = !m_held ? IDLE : (m_n >= LONG_MS ? LONG : PRESSED);
    exp_v = {e_press, e_short, e_long, e_rep, m_held};
    #1;
    cyc++;
    phase = (phase + 1) % 4;
    got_v = {press_pulse, short_pulse, long_pulse, repeat_pulse, held};
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL outputs cyc=%0d got {press,short,long,rep,held}=%b expected %b", cyc, got_v, exp_v);
    end
    n_tests++;
    if (state_dbg !== exp_s) begin
      n_fail++;
      $display("FAIL state cyc=%0d got %0d expected %0d", cyc, state_dbg, exp_s);
    end
    cnt_press += int'(press_pulse);
    cnt_short += int'(short_pulse);
    cnt_long  += int'(long_pulse);
    cnt_rep   += int'(repeat_pulse);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 0;
    clear_counts();
    for (int i = 0; i < 8; i++) cycle(1'b1, ptick());
    check_int("reset_no_pulses", cnt_press + cnt_short + cnt_long + cnt_rep, 0);
    rst = 1;
    clear_counts();
    cycle(1'b1, ptick());
    check_int("reset_release_press", int'(press_pulse), 1);
    check_int("reset_release_held", int'(held), 1);
    cycle(1'b0, ptick());
    cycle(1'b0, ptick());
  endtask

  task automatic test_short();
    int ticks = 0;
    clear_counts();
    cycle(1'b1, 1'b0);
    while (ticks < 2) begin
      logic tk = ptick();
      cycle(1'b1, tk);
      if (tk) ticks++;
    end
    cycle(1'b0, ptick());
    check_int("short_pulse_now", int'(short_pulse), 1);
    cycle(1'b0, ptick());
    check_int("short_press_cnt", cnt_press, 1);
    check_int("short_short_cnt", cnt_short, 1);
    check_int("short_long_cnt", cnt_long, 0);
  endtask

  task automatic test_long_repeat();
    int ticks = 0, long_at = -1, rep1 = -1, rep2 = -1;
    clear_counts();
    cycle(1'b1, 1'b0);
    while (ticks < 12) begin
      logic tk = ptick();
      cycle(1'b1, tk);
      if (tk) ticks++;
      if (long_pulse) long_at = ticks;
      if (repeat_pulse && rep1 < 0) rep1 = ticks;
      else if (repeat_pulse) rep2 = ticks;
    end
    check_int("long_tick", long_at, 5);
    check_int("repeat1_tick", rep1, 8);
    check_int("repeat2_tick", rep2, 11);
    cycle(1'b0, ptick());
    check_int("long_release_held", int'(held), 0);
    check_int("long_release_short", cnt_short, 0);
  endtask

  task automatic test_fall_wins();
    int ticks = 0;
    clear_counts();
    cycle(1'b1, 1'b0);
    while (ticks < 4) begin
      logic tk = ptick();
      cycle(1'b1, tk);
      if (tk) ticks++;
    end
    while (!ptick()) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    check_int("fallwin_short", int'(short_pulse), 1);
    check_int("fallwin_state", int'(state_dbg), int'(IDLE));
    cycle(1'b0, ptick());
    check_int("fallwin_long_cnt", cnt_long, 0);
  endtask

  task automatic test_reset_mid_hold();
    int ticks = 0;
    cycle(1'b1, 1'b0);
    while (ticks < 6) begin
      logic tk = ptick();
      cycle(1'b1, tk);
      if (tk) ticks++;
    end
    rst = 0;
    #1;
    check_int("midhold_async_held", int'(held), 0);
    clear_counts();
    for (int i = 0; i < 3; i++) cycle(1'b1, ptick());
    check_int("midhold_no_pulses", cnt_press + cnt_short + cnt_long + cnt_rep, 0);
    rst = 1;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
    check_int("midhold_press_once", cnt_press, 1);
    cycle(1'b0, ptick());
  endtask

  task automatic test_idle();
    clear_counts();
    for (int i = 0; i < 80; i++) cycle(1'b0, ptick());
    check_int("idle_no_pulses", cnt_press + cnt_short + cnt_long + cnt_rep, 0);
    check_int("idle_held", int'(held), 0);
  endtask

  task automatic test_random();
    logic lvl = 1'b0;
    for (int seg = 0; seg < 40; seg++) begin
      int len = $urandom_range(1, 60);
      lvl = ~lvl;
      for (int i = 0; i < len; i++) cycle(lvl, ($urandom_range(0, 3) == 0));
    end
    cycle(1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_short();
    test_long_repeat();
    test_fall_wins();
    test_reset_mid_hold();
    test_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
